matrix_axil_slave: RTL and testbench



---
 rtl/matrix_axil_pkg.sv | 15 +
 rtl/matrix_axil_slave_if.sv | 37 +++
 rtl/matrix_axil_regfile.sv | 51 +++++
 rtl/matrix_axil_slave.sv | 176 +++++++++++++++++
 tb/tb_matrix_axil_slave.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/matrix_axil_pkg.sv
// Shared constants, FSM state types and address helpers for the matrix core AXI4-Lite slave.
package matrix_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} wr_state_e;
  typedef enum logic {R_IDLE, R_DATA} rd_state_e;

  // Byte address to 32-bit word index; the low two address bits are ignored.
  function automatic int unsigned word_idx(input logic [31:0] addr);
    return addr >> 2;
  endfunction

endpackage

// File: rtl/matrix_axil_slave_if.sv
// AXI4-Lite channel bundle between the PS/VIP master and the matrix core register slave.
interface matrix_axil_slave_if #(
  parameter int unsigned AddrW = 7,
  parameter int unsigned DataW = 32
);
  logic [AddrW-1:0]   awaddr;
  logic [2:0]         awprot;
  logic               awvalid;
  logic               awready;
  logic [DataW-1:0]   wdata;
  logic [DataW/8-1:0] wstrb;
  logic               wvalid;
  logic               wready;
  logic [1:0]         bresp;
  logic               bvalid;
  logic               bready;
  logic [AddrW-1:0]   araddr;
  logic [2:0]         arprot;
  logic               arvalid;
  logic               arready;
  logic [DataW-1:0]   rdata;
  logic [1:0]         rresp;
  logic               rvalid;
  logic               rready;

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/matrix_axil_regfile.sv
// Byte-strobed read-write word storage plus the read mux over RW, RO and unmapped words.
module matrix_axil_regfile #(
  parameter int unsigned NumRw = 8,
  parameter int unsigned NumRo = 8,
  parameter int unsigned WordW = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [WordW-1:0]      wr_idx_i,
  input  logic [31:0]           wr_data_i,
  input  logic [3:0]            wr_strb_i,
  input  logic [WordW-1:0]      rd_idx_i,
  input  logic [32*NumRo-1:0]   ro_regs_i,
  output logic [31:0]           rd_data_o,
  output logic                  rd_err_o,
  output logic [32*NumRw-1:0]   rw_regs_o
);

  logic [31:0] regs_q [NumRw];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NumRw; i++) regs_q[i] <= '0;
    end else if (wr_en_i) begin
      for (int unsigned i = 0; i < NumRw; i++) begin
        if (32'(wr_idx_i) == i) begin
          for (int unsigned b = 0; b < 4; b++) begin
            if (wr_strb_i[b]) regs_q[i][8*b +: 8] <= wr_data_i[8*b +: 8];
          end
        end
      end
    end
  end

  for (genvar g = 0; g < NumRw; g++) begin : g_flat
    assign rw_regs_o[32*g +: 32] = regs_q[g];
  end

  always_comb begin
    rd_data_o = '0;
    rd_err_o  = 32'(rd_idx_i) >= (NumRw + NumRo);
    for (int unsigned i = 0; i < NumRw; i++) begin
      if (32'(rd_idx_i) == i) rd_data_o = regs_q[i];
    end
    for (int unsigned i = 0; i < NumRo; i++) begin
      if (32'(rd_idx_i) == NumRw + i) rd_data_o = ro_regs_i[32*i +: 32];
    end
  end

endmodule

// File: rtl/matrix_axil_slave.sv
// AXI4-Lite slave exposing the matrix core register bank; independent write and read FSMs,
// all AXI outputs registered or decoded from state only.
module matrix_axil_slave
  import matrix_axil_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 7,
  parameter int unsigned NUM_RW_REGS        = 8,
  parameter int unsigned NUM_RO_REGS        = 8,
  localparam int unsigned IdxW = (NUM_RW_REGS > 1) ? $clog2(NUM_RW_REGS) : 1
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  matrix_axil_slave_if.slave         s_axi,
  output logic [32*NUM_RW_REGS-1:0]  rw_regs,
  input  logic [32*NUM_RO_REGS-1:0]  ro_regs,
  output logic                       reg_wr_stb,
  output logic [IdxW-1:0]            reg_wr_idx
);

  localparam int unsigned WordW    = C_S_AXI_ADDR_WIDTH - 2;
  localparam int unsigned NumWords = NUM_RW_REGS + NUM_RO_REGS;

  wr_state_e                     wr_q, wr_d;
  logic [WordW-1:0]              aw_idx_q, aw_idx_d;
  logic [31:0]                   w_data_q, w_data_d;
  logic [3:0]                    w_strb_q, w_strb_d;
  logic [1:0]                    bresp_q, bresp_d;
  logic                          stb_q, stb_d;
  logic [IdxW-1:0]               stb_idx_q, stb_idx_d;
  rd_state_e                     rd_q, rd_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]                    rresp_q, rresp_d;

  logic             aw_hs, w_hs, ar_hs;
  logic             commit, commit_rw;
  logic [WordW-1:0] commit_idx, aw_word, ar_word;
  logic [31:0]      commit_data, rd_data;
  logic [3:0]       commit_strb;
  logic             rd_err;
  logic             unused_prot;

  assign unused_prot = ^{s_axi.awprot, s_axi.arprot};

  assign s_axi.awready = (wr_q == W_IDLE) || (wr_q == W_HAVE_D);
  assign s_axi.wready  = (wr_q == W_IDLE) || (wr_q == W_HAVE_A);
  assign s_axi.bvalid  = (wr_q == W_RESP);
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = (rd_q == R_IDLE);
  assign s_axi.rvalid  = (rd_q == R_DATA);
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;
  assign reg_wr_stb    = stb_q;
  assign reg_wr_idx    = stb_idx_q;

  assign aw_hs   = s_axi.awvalid && s_axi.awready;
  assign w_hs    = s_axi.wvalid && s_axi.wready;
  assign ar_hs   = s_axi.arvalid && s_axi.arready;
  assign aw_word = WordW'(word_idx(32'(s_axi.awaddr)));
  assign ar_word = WordW'(word_idx(32'(s_axi.araddr)));

  always_comb begin
    wr_d        = wr_q;
    aw_idx_d    = aw_idx_q;
    w_data_d    = w_data_q;
    w_strb_d    = w_strb_q;
    bresp_d     = bresp_q;
    commit      = 1'b0;
    commit_idx  = aw_idx_q;
    commit_data = w_data_q;
    commit_strb = w_strb_q;
    unique case (wr_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit      = 1'b1;
          commit_idx  = aw_word;
          commit_data = s_axi.wdata;
          commit_strb = s_axi.wstrb;
        end else if (aw_hs) begin
          aw_idx_d = aw_word;
          wr_d     = W_HAVE_A;
        end else if (w_hs) begin
          w_data_d = s_axi.wdata;
          w_strb_d = s_axi.wstrb;
          wr_d     = W_HAVE_D;
        end
      end
      W_HAVE_A: begin
        if (w_hs) begin
          commit      = 1'b1;
          commit_data = s_axi.wdata;
          commit_strb = s_axi.wstrb;
        end
      end
      W_HAVE_D: begin
        if (aw_hs) begin
          commit     = 1'b1;
          commit_idx = aw_word;
        end
      end
      W_RESP: if (s_axi.bready) wr_d = W_IDLE;
      default: wr_d = W_IDLE;
    endcase
    if (commit) begin
      wr_d    = W_RESP;
      bresp_d = (32'(commit_idx) >= NumWords) ? RESP_SLVERR : RESP_OKAY;
    end
  end

  // Only RW words store or strobe; RO and unmapped writes just get a response.
  assign commit_rw = commit && (32'(commit_idx) < NUM_RW_REGS);
  assign stb_d     = commit_rw;
  assign stb_idx_d = commit_rw ? IdxW'(commit_idx) : stb_idx_q;

  always_comb begin
    rd_d    = rd_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    unique case (rd_q)
      R_IDLE: begin
        if (ar_hs) begin
          rd_d    = R_DATA;
          rdata_d = rd_data;
          rresp_d = rd_err ? RESP_SLVERR : RESP_OKAY;
        end
      end
      R_DATA: if (s_axi.rready) rd_d = R_IDLE;
      default: rd_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_q      <= W_IDLE;
      aw_idx_q  <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp_q   <= RESP_OKAY;
      stb_q     <= 1'b0;
      stb_idx_q <= '0;
      rd_q      <= R_IDLE;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      wr_q      <= wr_d;
      aw_idx_q  <= aw_idx_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bresp_q   <= bresp_d;
      stb_q     <= stb_d;
      stb_idx_q <= stb_idx_d;
      rd_q      <= rd_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  matrix_axil_regfile #(
    .NumRw (NUM_RW_REGS),
    .NumRo (NUM_RO_REGS),
    .WordW (WordW)
  ) u_regfile (
    .clk_i     (ACLK),
    .rst_i     (ARESET),
    .wr_en_i   (commit_rw),
    .wr_idx_i  (commit_idx),
    .wr_data_i (commit_data),
    .wr_strb_i (commit_strb),
    .rd_idx_i  (ar_word),
    .ro_regs_i (ro_regs),
    .rd_data_o (rd_data),
    .rd_err_o  (rd_err),
    .rw_regs_o (rw_regs)
  );

endmodule

// File: tb/tb_matrix_axil_slave.sv
// Directed and randomized bench for matrix_axil_slave against a word-array register model.
module tb_matrix_axil_slave;
  import matrix_axil_pkg::*;

  logic         ACLK = 1'b0;
  logic         ARESET;
  logic [255:0] rw_regs;
  logic [255:0] ro_regs;
  logic         reg_wr_stb;
  logic [2:0]   reg_wr_idx;

  matrix_axil_slave_if #(.AddrW(7), .DataW(32)) axi ();

  matrix_axil_slave dut (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .s_axi      (axi),
    .rw_regs    (rw_regs),
    .ro_regs    (ro_regs),
    .reg_wr_stb (reg_wr_stb),
    .reg_wr_idx (reg_wr_idx)
  );

  always #5 ACLK = ~ACLK;

  int          n_checks = 0;
  int          n_errors = 0;
  int          stb_cnt  = 0;
  logic [31:0] model_rw [8];

  always @(negedge ACLK) if (reg_wr_stb === 1'b1) stb_cnt++;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] model_flat();
    logic [255:0] f;
    for (int i = 0; i < 8; i++) f[32*i +: 32] = model_rw[i];
    return f;
  endfunction

  function automatic void model_read(input logic [6:0] addr, output logic [31:0] d,
                                     output logic [1:0] r);
    int unsigned idx;
    idx = 32'(addr) / 4;
    d = '0;
    r = RESP_OKAY;
    if (idx < 8) d = model_rw[idx];
    else if (idx < 16) d = ro_regs[(idx - 8) * 32 +: 32];
    else r = RESP_SLVERR;
  endfunction

  function automatic void model_write(input logic [6:0] addr, input logic [31:0] d,
                                      input logic [3:0] strb, output logic [1:0] r,
                                      output logic s);
    int unsigned idx;
    idx = 32'(addr) / 4;
    r = (idx < 16) ? RESP_OKAY : RESP_SLVERR;
    s = (idx < 8);
    if (idx < 8) begin
      for (int b = 0; b < 4; b++) if (strb[b]) model_rw[idx][8*b +: 8] = d[8*b +: 8];
    end
  endfunction

  // lead > 0: W presented lead cycles before AW; lead < 0: AW first.
  task automatic do_write(input logic [6:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int lead, input int b_wait);
    logic [1:0] er;
    logic       es;
    int         base, cyc, aw_start, w_start;
    bit         aw_done, w_done, aw_fire, w_fire;
    base = stb_cnt;
    model_write(addr, data, strb, er, es);
    aw_start = (lead > 0) ? lead : 0;
    w_start  = (lead < 0) ? -lead : 0;
    axi.awaddr = addr;
    axi.wdata  = data;
    axi.wstrb  = strb;
    aw_done = 0;
    w_done  = 0;
    cyc     = 0;
    while (!(aw_done && w_done) && cyc < 50) begin
      if (!aw_done && cyc >= aw_start) axi.awvalid = 1'b1;
      if (!w_done && cyc >= w_start) axi.wvalid = 1'b1;
      aw_fire = axi.awvalid && axi.awready;
      w_fire  = axi.wvalid && axi.wready;
      @(posedge ACLK); #1;
      cyc++;
      if (aw_fire) begin aw_done = 1; axi.awvalid = 1'b0; end
      if (w_fire) begin w_done = 1; axi.wvalid = 1'b0; end
      if (!(aw_done && w_done)) begin
        check("bvalid_early", axi.bvalid, 0);
        if (w_done) check("wready_held", axi.wready, 0);
        if (aw_done) check("awready_held", axi.awready, 0);
      end
    end
    if (!(aw_done && w_done)) begin
      check("write_timeout", 0, 1);
      axi.awvalid = 1'b0;
      axi.wvalid  = 1'b0;
      return;
    end
    check("bvalid_latency", axi.bvalid, 1);
    check("bresp", axi.bresp, er);
    check("wr_stb", reg_wr_stb, es);
    if (es) check("wr_idx", reg_wr_idx, addr[4:2]);
    for (int i = 0; i < b_wait; i++) begin
      @(posedge ACLK); #1;
      check("bvalid_hold", axi.bvalid, 1);
      check("bresp_hold", axi.bresp, er);
      check("awready_busy", axi.awready, 0);
      check("wready_busy", axi.wready, 0);
    end
    axi.bready = 1'b1;
    @(posedge ACLK); #1;
    axi.bready = 1'b0;
    check("bvalid_clear", axi.bvalid, 0);
    check("awready_back", axi.awready, 1);
    check("stb_count", 32'(stb_cnt - base), es);
  endtask

  task automatic do_read(input logic [6:0] addr, input int r_wait);
    logic [31:0] ed;
    logic [1:0]  er;
    int          cyc;
    model_read(addr, ed, er);
    axi.araddr  = addr;
    axi.arvalid = 1'b1;
    cyc = 0;
    while (axi.arready !== 1'b1 && cyc < 50) begin
      @(posedge ACLK); #1;
      cyc++;
    end
    if (cyc >= 50) begin
      check("read_timeout", 0, 1);
      axi.arvalid = 1'b0;
      return;
    end
    @(posedge ACLK); #1;
    axi.arvalid = 1'b0;
    check("rvalid_latency", axi.rvalid, 1);
    check("rdata", axi.rdata, ed);
    check("rresp", axi.rresp, er);
    for (int i = 0; i < r_wait; i++) begin
      @(posedge ACLK); #1;
      check("rvalid_hold", axi.rvalid, 1);
      check("rdata_hold", axi.rdata, ed);
      check("arready_busy", axi.arready, 0);
    end
    axi.rready = 1'b1;
    @(posedge ACLK); #1;
    axi.rready = 1'b0;
    check("rvalid_clear", axi.rvalid, 0);
    check("arready_back", axi.arready, 1);
  endtask

  // Write and read handshake on the same edge; read expects the pre-write value.
  task automatic launch_both(input logic [6:0] waddr, input logic [31:0] wdata,
                             input logic [6:0] raddr);
    logic [31:0] ed;
    logic [1:0]  er, wr_r;
    logic        ws;
    model_read(raddr, ed, er);
    model_write(waddr, wdata, 4'hF, wr_r, ws);
    axi.awaddr  = waddr;
    axi.wdata   = wdata;
    axi.wstrb   = 4'hF;
    axi.araddr  = raddr;
    axi.awvalid = 1'b1;
    axi.wvalid  = 1'b1;
    axi.arvalid = 1'b1;
    @(posedge ACLK); #1;
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    axi.arvalid = 1'b0;
    check("both_bvalid", axi.bvalid, 1);
    check("both_rvalid", axi.rvalid, 1);
    check("both_rdata_old", axi.rdata, ed);
    check("both_bresp", axi.bresp, wr_r);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [6:0] a;
    axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 0;
    axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 0; axi.bready = 0;
    axi.araddr = '0; axi.arprot = '0; axi.arvalid = 0; axi.rready = 0;
    ro_regs = '0;
    for (int i = 0; i < 8; i++) model_rw[i] = '0;
    ARESET = 1'b1;
    repeat (2) @(posedge ACLK);
    #1;
    ARESET = 1'b0;

    check("rst_awready", axi.awready, 1);
    check("rst_wready", axi.wready, 1);
    check("rst_arready", axi.arready, 1);
    check("rst_bvalid", axi.bvalid, 0);
    check("rst_rvalid", axi.rvalid, 0);
    check("rst_resp", {axi.bresp, axi.rresp}, 0);
    check("rst_rdata", axi.rdata, 0);
    check("rst_rw_regs", rw_regs, 0);
    check("rst_stb", {reg_wr_stb, reg_wr_idx}, 0);

    for (int i = 0; i < 4; i++) do_write(7'(4 * i), 32'(i + 1), 4'hF, 0, 0);
    for (int i = 0; i < 4; i++) do_read(7'(4 * i), 0);
    check("seq_flat", {128'b0, rw_regs[127:0]},
          {128'b0, 128'h00000004_00000003_00000002_00000001});

    do_write(7'h10, 32'hAABBCCDD, 4'hF, 0, 0);
    do_write(7'h10, 32'h11223344, 4'b0101, 0, 0);
    do_read(7'h10, 1);
    check("partial_strobe", {224'b0, rw_regs[159:128]}, {224'b0, 32'hAA22CC44});
    do_write(7'h14, 32'h0BADF00D, 4'h0, -2, 0);

    do_write(7'h18, 32'h13572468, 4'hF, 3, 0);
    do_write(7'h1C, 32'hCAFEF00D, 4'hF, 0, 5);

    ro_regs[31:0] = 32'hDEADBEEF;
    do_read(7'h20, 0);
    do_write(7'h20, 32'h12345678, 4'hF, 0, 0);
    do_read(7'h20, 0);
    do_read(7'h7C, 2);
    do_write(7'h7C, 32'hFFFFFFFF, 4'hF, 1, 1);

    do_write(7'h00, 32'h5, 4'hF, 0, 0);
    launch_both(7'h00, 32'h9, 7'h00);
    axi.bready = 1'b1;
    axi.rready = 1'b1;
    @(posedge ACLK); #1;
    axi.bready = 1'b0;
    axi.rready = 1'b0;
    check("both_drain", {axi.bvalid, axi.rvalid}, 0);
    do_read(7'h00, 0);

    for (int n = 0; n < 60; n++) begin
      a = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 3) != 0) a = 7'($urandom_range(0, 63));
      case ($urandom_range(0, 4))
        0, 1: do_write(a, $urandom, 4'($urandom), $urandom_range(0, 6) - 3,
                       $urandom_range(0, 2));
        2, 3: do_read(a, $urandom_range(0, 2));
        default: for (int i = 0; i < 8; i++) ro_regs[32*i +: 32] = $urandom;
      endcase
    end
    check("rand_flat", rw_regs, model_flat());

    launch_both(7'h04, 32'h77, 7'h08);
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    for (int i = 0; i < 8; i++) model_rw[i] = '0;
    check("midrst_valids", {axi.bvalid, axi.rvalid}, 0);
    check("midrst_readies", {axi.awready, axi.wready, axi.arready}, 3'b111);
    check("midrst_rw_regs", rw_regs, 0);
    check("midrst_stb", reg_wr_stb, 0);
    do_read(7'h04, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
